// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - registered multi-cycle ALU for the AC/DR/E datapath
module alu_seq_unit #(
    parameter int WIDTH = 16,
    parameter int INW   = 8,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_code,
    input  logic [WIDTH-1:0] ac_outdata,
    input  logic [WIDTH-1:0] dr_outdata,
    input  logic             e_outdata,
    input  logic [INW-1:0]   inpr_outdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_outdata,
    output logic             e_indata,
    output logic             ac_ld,
    output logic             ff_en
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1) + 1;

    localparam logic [3:0] OP_CLA  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_LDA  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_CMA  = 4'b1001;
    localparam logic [3:0] OP_CME  = 4'b1010;
    localparam logic [3:0] OP_CIR  = 4'b1011;
    localparam logic [3:0] OP_CIL  = 4'b1100;
    localparam logic [3:0] OP_INP  = 4'b1101;
    localparam logic [3:0] OP_CIRN = 4'b1110;
    localparam logic [3:0] OP_CILN = 4'b1111;

    localparam logic [WIDTH-1:0] INP_MASK = (WIDTH'(1) << INW) - WIDTH'(1);

    state_t             state_q, state_d;
    logic [3:0]         code_q;
    logic [WIDTH-1:0]   ac_q, dr_q;
    logic               e_q;
    logic [INW-1:0]     inpr_q;
    logic [CW-1:0]      cnt_q, steps_q, steps_start;
    logic [2*WIDTH-1:0] prod_q, prod_step;
    logic [WIDTH-1:0]   ac_step;
    logic               e_step;
    logic [WIDTH:0]     hi_sum;
    logic               wr_ac, wr_e;
    logic               rot_zero, last_step;

    assign busy      = (state_q != S_IDLE);
    assign last_step = (cnt_q == steps_q);
    assign rot_zero  = (dr_q[SHW-1:0] == '0);

    // Number of EXEC step cycles; a zero-length rotate still spends one cycle.
    always_comb begin
        steps_start = CW'(1);
        if (alu_code == OP_MUL) begin
            steps_start = CW'(WIDTH);
        end else if ((alu_code == OP_CIRN || alu_code == OP_CILN) && dr_outdata[SHW-1:0] != '0) begin
            steps_start = CW'(dr_outdata[SHW-1:0]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_EXEC;
            S_EXEC:  if (last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One step of the latched operation; the working AC/E registers are updated in place.
    always_comb begin
        ac_step   = ac_q;
        e_step    = e_q;
        prod_step = prod_q;
        hi_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, ac_q} : '0);
        case (code_q)
            OP_CLA:  ac_step = '0;
            OP_AND:  ac_step = ac_q & dr_q;
            OP_ADD:  {e_step, ac_step} = {1'b0, ac_q} + {1'b0, dr_q};
            OP_LDA:  ac_step = dr_q;
            OP_SUB:  {e_step, ac_step} = {1'b0, ac_q} + {1'b0, ~dr_q} + (WIDTH+1)'(1);
            OP_CMA:  ac_step = ~ac_q;
            OP_CME:  e_step = ~e_q;
            OP_CIR:  {ac_step, e_step} = {e_q, ac_q};
            OP_CIL:  {e_step, ac_step} = {ac_q, e_q};
            OP_INP:  ac_step = (ac_q & ~INP_MASK) | WIDTH'(inpr_q);
            OP_MUL:  prod_step = {hi_sum, prod_q[WIDTH-1:1]};
            OP_CIRN: if (!rot_zero) {ac_step, e_step} = {e_q, ac_q};
            OP_CILN: if (!rot_zero) {e_step, ac_step} = {ac_q, e_q};
            default: ;
        endcase
    end

    always_comb begin
        wr_ac = 1'b0;
        wr_e  = 1'b0;
        case (code_q)
            OP_CLA, OP_AND, OP_LDA, OP_CMA, OP_INP: wr_ac = 1'b1;
            OP_ADD, OP_SUB, OP_CIR, OP_CIL, OP_MUL, OP_CIRN, OP_CILN: begin
                wr_ac = 1'b1;
                wr_e  = 1'b1;
            end
            OP_CME:  wr_e = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            ac_q        <= '0;
            dr_q        <= '0;
            e_q         <= 1'b0;
            inpr_q      <= '0;
            cnt_q       <= '0;
            steps_q     <= '0;
            prod_q      <= '0;
            done        <= 1'b0;
            ac_ld       <= 1'b0;
            ff_en       <= 1'b0;
            alu_outdata <= '0;
            e_indata    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            ac_ld   <= 1'b0;
            ff_en   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        code_q  <= alu_code;
                        ac_q    <= ac_outdata;
                        dr_q    <= dr_outdata;
                        e_q     <= e_outdata;
                        inpr_q  <= inpr_outdata;
                        cnt_q   <= '0;
                        steps_q <= steps_start;
                        prod_q  <= {{WIDTH{1'b0}}, dr_outdata};
                    end
                end
                S_EXEC: begin
                    if (last_step) begin
                        done  <= 1'b1;
                        ac_ld <= wr_ac;
                        ff_en <= wr_e;
                        if (wr_ac) alu_outdata <= (code_q == OP_MUL) ? prod_q[WIDTH-1:0] : ac_q;
                        if (wr_e)  e_indata    <= (code_q == OP_MUL) ? |prod_q[2*WIDTH-1:WIDTH] : e_q;
                    end else begin
                        ac_q   <= ac_step;
                        e_q    <= e_step;
                        prod_q <= prod_step;
                        cnt_q  <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - scoreboard bench for alu_seq_unit
module tb_alu_seq_unit;

    typedef struct {
        logic [15:0] alu;
        logic        e;
        logic        ld;
        logic        ff;
        int          k;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  alu_code;
    logic [15:0] ac_outdata, dr_outdata;
    logic        e_outdata;
    logic [7:0]  inpr_outdata;
    logic        busy, done, e_indata, ac_ld, ff_en;
    logic [15:0] alu_outdata;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    exp_t        sb[$];
    exp_t        mx;
    logic [15:0] m_alu = '0;
    logic        m_e = 1'b0;

    alu_seq_unit #(.WIDTH(16), .INW(8), .SHW(4)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_code(alu_code),
        .ac_outdata(ac_outdata), .dr_outdata(dr_outdata), .e_outdata(e_outdata),
        .inpr_outdata(inpr_outdata), .busy(busy), .done(done),
        .alu_outdata(alu_outdata), .e_indata(e_indata), .ac_ld(ac_ld), .ff_en(ff_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [15:0] a, input logic [15:0] d,
                                   input logic e, input logic [7:0] p);
        exp_t        r;
        logic [16:0] s;
        logic [31:0] prod;
        logic [16:0] rot;
        int          n;
        r.alu = m_alu; r.e = m_e; r.ld = 1'b0; r.ff = 1'b0; r.k = 1; r.cyc = 0;
        rot = {e, a};
        case (c)
            4'h0: begin r.alu = 16'h0000; r.ld = 1'b1; end
            4'h1: begin r.alu = a & d; r.ld = 1'b1; end
            4'h2: begin s = {1'b0, a} + {1'b0, d}; r.alu = s[15:0]; r.e = s[16]; r.ld = 1'b1; r.ff = 1'b1; end
            4'h3: begin r.alu = d; r.ld = 1'b1; end
            4'h4: begin
                prod = {16'h0, a} * {16'h0, d};
                r.alu = prod[15:0]; r.e = (prod[31:16] != 16'h0); r.k = 16; r.ld = 1'b1; r.ff = 1'b1;
            end
            4'h5: begin r.alu = a - d; r.e = (a >= d); r.ld = 1'b1; r.ff = 1'b1; end
            4'h9: begin r.alu = ~a; r.ld = 1'b1; end
            4'ha: begin r.e = ~e; r.ff = 1'b1; end
            4'hb: begin rot = {rot[0], rot[16:1]}; r.alu = rot[15:0]; r.e = rot[16]; r.ld = 1'b1; r.ff = 1'b1; end
            4'hc: begin rot = {rot[15:0], rot[16]}; r.alu = rot[15:0]; r.e = rot[16]; r.ld = 1'b1; r.ff = 1'b1; end
            4'hd: begin r.alu = {a[15:8], p}; r.ld = 1'b1; end
            4'he, 4'hf: begin
                n = int'(d[3:0]);
                for (int i = 0; i < n; i++)
                    rot = (c == 4'he) ? {rot[0], rot[16:1]} : {rot[15:0], rot[16]};
                r.alu = rot[15:0]; r.e = rot[16]; r.k = (n == 0) ? 1 : n; r.ld = 1'b1; r.ff = 1'b1;
            end
            default: ;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                mx = sb.pop_front();
                chk("done_cycle", cyc, mx.cyc);
                chk("alu_outdata", alu_outdata, mx.alu);
                chk("e_indata", e_indata, mx.e);
                chk("ac_ld", ac_ld, mx.ld);
                chk("ff_en", ff_en, mx.ff);
            end
        end
        if (!reset && !done && (ac_ld || ff_en)) chk("ld_without_done", {ac_ld, ff_en}, 0);
    end

    task automatic run(input logic [3:0] c, input logic [15:0] a, input logic [15:0] d,
                       input logic e, input logic [7:0] p, input bit poke);
        exp_t x;
        x = model(c, a, d, e, p);
        alu_code = c; ac_outdata = a; dr_outdata = d; e_outdata = e; inpr_outdata = p;
        start = 1'b1;
        x.cyc = cyc + 2 + x.k;
        sb.push_back(x);
        m_alu = x.alu;
        m_e = x.e;
        @(negedge clk);
        chk("busy_exec", busy, 1);
        start = poke;
        alu_code = ~c; ac_outdata = ~a; dr_outdata = ~d; e_outdata = ~e; inpr_outdata = ~p;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
            start = poke && done;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_done", busy, 0);
        chk("done_width", done, 0);
        chk("hold_alu", alu_outdata, m_alu);
        if (poke) repeat (5) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; alu_code = '0;
        ac_outdata = '0; dr_outdata = '0; e_outdata = 1'b0; inpr_outdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_alu", alu_outdata, 0);
        chk("rst_e", e_indata, 0);
        chk("rst_ld", {ac_ld, ff_en}, 0);

        run(4'h2, 16'hFFFF, 16'h0001, 1'b0, 8'h00, 0);
        run(4'h4, 16'h0123, 16'h0010, 1'b1, 8'h00, 0);
        run(4'h4, 16'h8000, 16'h0002, 1'b0, 8'h00, 0);
        run(4'he, 16'h0001, 16'h0002, 1'b0, 8'h00, 0);
        run(4'he, 16'h1234, 16'h0000, 1'b1, 8'h00, 0);
        run(4'hf, 16'hC001, 16'h0003, 1'b1, 8'h00, 0);
        run(4'hf, 16'h8421, 16'h000F, 1'b0, 8'h00, 0);
        run(4'h5, 16'h0005, 16'h0007, 1'b0, 8'h00, 0);
        run(4'h5, 16'h0009, 16'h0007, 1'b0, 8'h00, 0);
        run(4'hd, 16'hAB00, 16'h0000, 1'b1, 8'h5C, 0);
        run(4'h2, 16'h1111, 16'h2222, 1'b1, 8'h00, 1);
        run(4'h7, 16'hDEAD, 16'hBEEF, 1'b1, 8'hFF, 0);
        run(4'ha, 16'h0000, 16'h0000, 1'b0, 8'h00, 0);
        run(4'h0, 16'h5555, 16'h0000, 1'b0, 8'h00, 0);
        run(4'h1, 16'hF0F0, 16'h3C3C, 1'b0, 8'h00, 0);
        run(4'h3, 16'h0000, 16'hBEEF, 1'b0, 8'h00, 0);
        run(4'h9, 16'h00FF, 16'h0000, 1'b0, 8'h00, 0);
        run(4'hb, 16'h0003, 16'h0000, 1'b1, 8'h00, 0);
        run(4'hc, 16'h8001, 16'h0000, 1'b0, 8'h00, 0);
        run(4'h6, 16'h1234, 16'h5678, 1'b0, 8'h00, 0);
        run(4'h8, 16'h1234, 16'h5678, 1'b1, 8'h00, 0);
        for (int i = 0; i < 24; i++)
            run(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'($urandom), 8'($urandom), 0);

        run(4'h3, 16'h0000, 16'hBEEF, 1'b1, 8'h00, 0);
        alu_code = 4'h4; ac_outdata = 16'h0123; dr_outdata = 16'h0010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_alu = '0;
        m_e = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_alu", alu_outdata, 16'h0000);
        chk("abort_e", e_indata, 0);
        run(4'h4, 16'h00FF, 16'h0101, 1'b0, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
